// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one 32-bit comparator among NREQ requesters.
// Operands and results are registered on either side of the comparator, giving a two-cycle response.
module cmp_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sig,
    output logic [NREQ-1:0]      resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_eq,
    output logic                 resp_lt,
    output logic                 resp_gt
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_a_q, s1_a_d;
    logic [31:0]     s1_b_q, s1_b_d;
    logic            s1_sig_q, s1_sig_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic            resp_eq_q, resp_eq_d;
    logic            resp_lt_q, resp_lt_d;
    logic            resp_gt_q, resp_gt_d;

    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic            found;
    logic            grant;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  scan_idx;
    logic            cmp_eq, cmp_lt, cmp_gt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[32*i +: 32];
            b_arr[i] = req_b[32*i +: 32];
        end
    end

    // Scan starts at ptr so the most recently served requester is considered last.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign grant     = found && !stall && !reset;
    assign req_ready = grant ? (NREQ'(1) << winner) : '0;

    assign cmp_eq = (s1_a_q == s1_b_q);
    assign cmp_lt = s1_sig_q ? ($signed(s1_a_q) < $signed(s1_b_q)) : (s1_a_q < s1_b_q);
    assign cmp_gt = !cmp_eq && !cmp_lt;

    always_comb begin
        ptr_d        = ptr_q;
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_sig_d     = s1_sig_q;
        s1_id_d      = s1_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_eq_d    = resp_eq_q;
        resp_lt_d    = resp_lt_q;
        resp_gt_d    = resp_gt_q;

        if (grant) begin
            ptr_d    = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            s1_a_d   = a_arr[winner];
            s1_b_d   = b_arr[winner];
            s1_sig_d = req_sig[winner];
            s1_id_d  = winner;
        end

        // A flushed op still advances ptr above; only its valid bits are dropped.
        if (flush) begin
            s1_valid_d   = 1'b0;
            resp_valid_d = '0;
        end else if (!stall) begin
            s1_valid_d   = grant;
            resp_valid_d = s1_valid_q ? (NREQ'(1) << s1_id_q) : '0;
            if (s1_valid_q) begin
                resp_id_d = s1_id_q;
                resp_eq_d = cmp_eq;
                resp_lt_d = cmp_lt;
                resp_gt_d = cmp_gt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_sig_q     <= 1'b0;
            s1_id_q      <= '0;
            resp_valid_q <= '0;
            resp_id_q    <= '0;
            resp_eq_q    <= 1'b0;
            resp_lt_q    <= 1'b0;
            resp_gt_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_sig_q     <= s1_sig_d;
            s1_id_q      <= s1_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_eq_q    <= resp_eq_d;
            resp_lt_q    <= resp_lt_d;
            resp_gt_q    <= resp_gt_d;
        end
    end

    // A held result stays in resp_valid_q and reappears once stall drops.
    assign resp_valid = stall ? '0 : resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_eq    = resp_eq_q;
    assign resp_lt    = resp_lt_q;
    assign resp_gt    = resp_gt_q;

endmodule
